inst_word_assembler: RTL and testbench
======================================

Name: inst_word_assembler

Overview:
- Decode-side consumer of the fetch stage's instruction stream, behind the instruction memory.
- Accepts one 16-bit word plus its PC per cycle and assembles single-word or two-word (opcode + 16-bit immediate) instructions.
- Hands a complete instruction bundle to decode through a valid/ready handshake.
- Drives back-pressure (stall) to fetch and discards partial or pending instructions on a branch/interrupt flush.

Parameters:
- IMM_FLAG_BIT, 0, bit of the first word that marks a two-word instruction (1 = immediate word follows).
- WORD_W, 16, instruction word width.
- PC_W, 32, program-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  fetch presents a word this cycle.
- in_word  in  WORD_W  fetched word.
- in_pc  in  PC_W  address of in_word.
- flush  in  1  branch taken or interrupt; drop everything held.
- fetch_stall  out  1  fetch must hold its PC; equals NOT in_ready.
- out_valid  out  1  bundle available to decode.
- out_ready  in  1  decode accepts the bundle this cycle.
- out_inst  out  WORD_W  opcode word.
- out_imm  out  WORD_W  immediate word; 0 when out_has_imm = 0.
- out_has_imm  out  1  bundle is a two-word instruction.
- out_pc  out  PC_W  PC of the opcode word.

Behaviour:
- Reset (synchronous, active-high): state = S_FIRST; out_valid = 0; out_inst = 0; out_imm = 0; out_has_imm = 0; out_pc = 0. fetch_stall = 0 after reset.
- in_ready is asserted when state is not S_FULL, or when out_ready = 1 (accept-while-draining).
- A word transfers when in_valid = 1 and in_ready = 1.
- Reset has priority over flush; flush has priority over everything else.
- S_FIRST (waiting for opcode):
  - On transfer, latch in_word into out_inst and in_pc into out_pc.
  - If in_word[IMM_FLAG_BIT] = 1, go to S_IMM.
  - Otherwise set out_imm = 0 and out_has_imm = 0, raise out_valid, and go to S_FULL.
- S_IMM (waiting for immediate):
  - On transfer, latch in_word into out_imm and set out_has_imm = 1.
  - Raise out_valid and go to S_FULL. in_pc of the immediate word is ignored.
- S_FULL (bundle held):
  - Outputs are stable while out_ready = 0; fetch_stall = 1.
  - If out_ready = 1 and no transfer: out_valid goes to 0 next cycle and state goes to S_FIRST.
  - If out_ready = 1 and a transfer occurs in the same cycle: the word is processed as in S_FIRST. Next cycle holds either the new single-word bundle (out_valid stays 1) or S_IMM (out_valid = 0).
- Latency: single-word instruction is valid 1 cycle after its transfer; two-word instruction is valid 1 cycle after the immediate transfers.
- Throughput: one single-word instruction per cycle at full rate.
- flush = 1 (any state):
  - Next cycle: state = S_FIRST and out_valid = 0.
  - Any partial opcode in S_IMM is discarded; a word presented in the flush cycle is dropped.
  - out_inst and out_pc keep their stale values; out_imm and out_has_imm clear to 0.
  - An out_ready handshake in the flush cycle is not counted as a delivery.
- in_valid = 0 in any state: hold.
- Reset mid-instruction behaves exactly like flush, plus output data regs clear.
- No PC arithmetic is performed; out_pc is passed through unchanged at full width.

Optional Feature:
- INST_WORD_ASSEMBLER_STATS_EN defined: adds outputs stat_insts[31:0], stat_imm_insts[31:0] and stat_flushed[15:0].
  - stat_insts counts delivered bundles (out_valid AND out_ready, no flush).
  - stat_imm_insts counts the subset of delivered bundles with out_has_imm = 1.
  - stat_flushed counts flush cycles in which a partial opcode or an undelivered bundle was discarded.
  - All counters clear on reset, wrap modulo 2^width, and are not cleared by flush.
- Undefined: those ports and counters are absent; functional behaviour is identical.

Decomposition:
- Package inst_asm_pkg holds:
  - state encoding S_FIRST = 2'd0, S_IMM = 2'd1, S_FULL = 2'd2 (2'd3 is illegal and recovers to S_FIRST);
  - default IMM_FLAG_BIT;
  - WORD_W and PC_W constants shared with fetch and decode.
- One natural sub-module: inst_asm_stats (counter block), instantiated only under INST_WORD_ASSEMBLER_STATS_EN.

Test Plan:
- Reset, then words 0x1000 / 0x1002 / 0x1004 at PCs 0x20 / 0x21 / 0x22 with out_ready = 1:
  - three bundles on consecutive cycles, out_has_imm = 0, out_pc = 0x20 / 0x21 / 0x22, fetch_stall never asserted.
- Word 0x3001 at PC 0x40, then 0xBEEF:
  - one bundle with out_inst = 0x3001, out_imm = 0xBEEF, out_has_imm = 1, out_pc = 0x40;
  - out_valid is 0 in the cycle after the first word.
- Bundle held with out_ready = 0 for 3 cycles:
  - fetch_stall = 1 for those cycles and outputs are stable;
  - on out_ready = 1 with next word 0x2000, that word is accepted in the same cycle and out_valid stays 1.
- Word 0x5001 accepted (now in S_IMM), then flush with in_valid = 1 and word 0x1234:
  - no bundle emitted, next cycle is S_FIRST;
  - the following word 0x0A00 at PC 0x0 emits as a single-word bundle.
- Reset asserted while S_FULL with out_valid = 1:
  - next cycle all outputs are 0 and fetch_stall = 0.
- With INST_WORD_ASSEMBLER_STATS_EN: 5 single-word and 2 two-word deliveries plus 1 flush of a partial opcode:
  - stat_insts = 7, stat_imm_insts = 2, stat_flushed = 1.

Source files
------------

// File: rtl/inst_asm_pkg.sv
// Shared definitions for the instruction word assembler: state encoding,
// default word/PC widths used by fetch and decode, and the default bit that
// marks a two-word (opcode + immediate) instruction.
package inst_asm_pkg;

   localparam int WORD_W       = 16;
   localparam int PC_W         = 32;
   localparam int IMM_FLAG_BIT = 0;

   // Statistics counter widths (only used when the stats block is built)
   localparam int STAT_INST_W  = 32;
   localparam int STAT_FLUSH_W = 16;

   // 2'd3 is unused and recovers to S_FIRST
   typedef enum logic [1:0] {
      S_FIRST = 2'd0,
      S_IMM   = 2'd1,
      S_FULL  = 2'd2
   } asm_state_e;

endpackage

// File: rtl/inst_asm_stats.sv
// Delivery / discard counters for the instruction word assembler.
// Built only when INST_WORD_ASSEMBLER_STATS_EN is defined. Counters wrap and
// are cleared only by reset.
module inst_asm_stats (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 deliver,
   input  logic                                 deliver_imm,
   input  logic                                 discard,
   output logic [inst_asm_pkg::STAT_INST_W-1:0]  stat_insts,
   output logic [inst_asm_pkg::STAT_INST_W-1:0]  stat_imm_insts,
   output logic [inst_asm_pkg::STAT_FLUSH_W-1:0] stat_flushed
);
   import inst_asm_pkg::*;

   logic [STAT_INST_W-1:0]  insts_q, insts_d;
   logic [STAT_INST_W-1:0]  imm_insts_q, imm_insts_d;
   logic [STAT_FLUSH_W-1:0] flushed_q, flushed_d;

   // Next counter values: bump on each qualifying event, wrap naturally
   always_comb begin
      insts_d     = insts_q;
      imm_insts_d = imm_insts_q;
      flushed_d   = flushed_q;
      if (deliver) begin
         insts_d = insts_q + 1'b1;
      end
      if (deliver_imm) begin
         imm_insts_d = imm_insts_q + 1'b1;
      end
      if (discard) begin
         flushed_d = flushed_q + 1'b1;
      end
   end

   // Counter registers, cleared only on reset
   always_ff @(posedge clk) begin
      if (reset) begin
         insts_q     <= '0;
         imm_insts_q <= '0;
         flushed_q   <= '0;
      end else begin
         insts_q     <= insts_d;
         imm_insts_q <= imm_insts_d;
         flushed_q   <= flushed_d;
      end
   end

   assign stat_insts     = insts_q;
   assign stat_imm_insts = imm_insts_q;
   assign stat_flushed   = flushed_q;

endmodule

// File: rtl/inst_word_assembler.sv
// Instruction word assembler: gathers one or two 16-bit fetch words into an
// instruction bundle for decode, back-pressures fetch while a bundle is held,
// and drops partial/pending work on flush.
// Optional: define INST_WORD_ASSEMBLER_STATS_EN to add delivery counters.
module inst_word_assembler #(
   parameter int IMM_FLAG_BIT = inst_asm_pkg::IMM_FLAG_BIT,
   parameter int WORD_W       = inst_asm_pkg::WORD_W,
   parameter int PC_W         = inst_asm_pkg::PC_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_word,
   input  logic [PC_W-1:0]   in_pc,
   input  logic              flush,
   output logic              fetch_stall,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_inst,
   output logic [WORD_W-1:0] out_imm,
   output logic              out_has_imm,
   output logic [PC_W-1:0]   out_pc
`ifdef INST_WORD_ASSEMBLER_STATS_EN
   ,
   output logic [31:0]       stat_insts,
   output logic [31:0]       stat_imm_insts,
   output logic [15:0]       stat_flushed
`endif
);
   import inst_asm_pkg::*;

   asm_state_e        state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [WORD_W-1:0] out_inst_q, out_inst_d;
   logic [WORD_W-1:0] out_imm_q, out_imm_d;
   logic              out_has_imm_q, out_has_imm_d;
   logic [PC_W-1:0]   out_pc_q, out_pc_d;

   logic in_ready;
   logic xfer;

   // A held bundle blocks fetch unless decode drains it this same cycle
   assign in_ready    = (state_q != S_FULL) || out_ready;
   assign xfer        = in_valid && in_ready;
   assign fetch_stall = !in_ready;

   // Next-state and output-register computation; flush wins over all traffic
   always_comb begin
      state_d       = state_q;
      out_valid_d   = out_valid_q;
      out_inst_d    = out_inst_q;
      out_imm_d     = out_imm_q;
      out_has_imm_d = out_has_imm_q;
      out_pc_d      = out_pc_q;
      if (flush) begin
         state_d       = S_FIRST;
         out_valid_d   = 1'b0;
         out_imm_d     = '0;
         out_has_imm_d = 1'b0;
      end else begin
         case (state_q)
            S_FIRST, S_FULL: begin
               if (state_q == S_FULL && out_ready) begin
                  state_d     = S_FIRST;
                  out_valid_d = 1'b0;
               end
               if (xfer) begin
                  out_inst_d = in_word;
                  out_pc_d   = in_pc;
                  if (in_word[IMM_FLAG_BIT]) begin
                     state_d     = S_IMM;
                     out_valid_d = 1'b0;
                  end else begin
                     state_d       = S_FULL;
                     out_valid_d   = 1'b1;
                     out_imm_d     = '0;
                     out_has_imm_d = 1'b0;
                  end
               end
            end
            S_IMM: begin
               if (xfer) begin
                  state_d       = S_FULL;
                  out_valid_d   = 1'b1;
                  out_imm_d     = in_word;
                  out_has_imm_d = 1'b1;
               end
            end
            default: begin
               state_d     = S_FIRST;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and registered bundle outputs; reset clears everything
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_FIRST;
         out_valid_q   <= 1'b0;
         out_inst_q    <= '0;
         out_imm_q     <= '0;
         out_has_imm_q <= 1'b0;
         out_pc_q      <= '0;
      end else begin
         state_q       <= state_d;
         out_valid_q   <= out_valid_d;
         out_inst_q    <= out_inst_d;
         out_imm_q     <= out_imm_d;
         out_has_imm_q <= out_has_imm_d;
         out_pc_q      <= out_pc_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_inst    = out_inst_q;
   assign out_imm     = out_imm_q;
   assign out_has_imm = out_has_imm_q;
   assign out_pc      = out_pc_q;

`ifdef INST_WORD_ASSEMBLER_STATS_EN
   logic deliver;
   logic deliver_imm;
   logic discard;

   // A handshake during flush is not a delivery; a flush discards work only
   // when a partial opcode or an undelivered bundle is held
   assign deliver     = out_valid_q && out_ready && !flush;
   assign deliver_imm = deliver && out_has_imm_q;
   assign discard     = flush && ((state_q == S_IMM) || (state_q == S_FULL));

   inst_asm_stats u_stats (
      .clk            (clk),
      .reset          (reset),
      .deliver        (deliver),
      .deliver_imm    (deliver_imm),
      .discard        (discard),
      .stat_insts     (stat_insts),
      .stat_imm_insts (stat_imm_insts),
      .stat_flushed   (stat_flushed)
   );
`endif

endmodule

// File: tb/tb_inst_word_assembler.sv
// Self-checking bench for inst_word_assembler: a transaction-level model of
// pending opcode / held bundle is compared with the DUT every cycle, and
// directed steps pin hand-computed values.
module tb_inst_word_assembler;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [15:0] in_word;
   logic [31:0] in_pc;
   logic        flush;
   logic        fetch_stall;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_inst;
   logic [15:0] out_imm;
   logic        out_has_imm;
   logic [31:0] out_pc;
`ifdef INST_WORD_ASSEMBLER_STATS_EN
   logic [31:0] stat_insts;
   logic [31:0] stat_imm_insts;
   logic [15:0] stat_flushed;
`endif

   int checks = 0;
   int errors = 0;

   inst_word_assembler dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_word     (in_word),
      .in_pc       (in_pc),
      .flush       (flush),
      .fetch_stall (fetch_stall),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_inst    (out_inst),
      .out_imm     (out_imm),
      .out_has_imm (out_has_imm),
      .out_pc      (out_pc)
`ifdef INST_WORD_ASSEMBLER_STATS_EN
      ,
      .stat_insts     (stat_insts),
      .stat_imm_insts (stat_imm_insts),
      .stat_flushed   (stat_flushed)
`endif
   );

   // Clock generation, 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: an opcode waiting for its immediate, and a bundle awaiting decode
   bit        m_ok = 0;
   bit        m_pend;
   bit        m_full;
   bit [15:0] m_inst;
   bit [15:0] m_imm;
   bit        m_has;
   bit [31:0] m_pc;
   int        m_delivered;
   int        m_delivered_imm;
   int        m_flushed;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update from the inputs sampled at each rising edge
   always @(posedge clk) begin
      if (reset) begin
         m_ok = 1; m_pend = 0; m_full = 0; m_inst = 0; m_imm = 0; m_has = 0; m_pc = 0;
         m_delivered = 0; m_delivered_imm = 0; m_flushed = 0;
      end else if (m_ok) begin
         if (flush) begin
            if (m_pend || m_full) m_flushed++;
            m_pend = 0; m_full = 0; m_imm = 0; m_has = 0;
         end else begin
            bit take;
            take = in_valid && (!m_full || out_ready);
            if (m_full && out_ready) begin
               m_delivered++;
               if (m_has) m_delivered_imm++;
               m_full = 0;
            end
            if (take) begin
               if (m_pend) begin
                  m_imm = in_word; m_has = 1; m_full = 1; m_pend = 0;
               end else begin
                  m_inst = in_word; m_pc = in_pc;
                  if (in_word[0]) m_pend = 1;
                  else begin m_imm = 0; m_has = 0; m_full = 1; end
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (m_ok) begin
         checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_full});
         checkOutput("fetch_stall", {31'd0, fetch_stall}, {31'd0, m_full && !out_ready});
         if (m_full) begin
            checkOutput("out_inst", {16'd0, out_inst}, {16'd0, m_inst});
            checkOutput("out_imm", {16'd0, out_imm}, {16'd0, m_imm});
            checkOutput("out_has_imm", {31'd0, out_has_imm}, {31'd0, m_has});
            checkOutput("out_pc", out_pc, m_pc);
         end
      end
   end

   // Drive one cycle of inputs shortly after the rising edge, then wait for
   // the falling edge so callers can inspect outputs
   task automatic applyStimulus(input logic rst, input logic v, input logic [15:0] w,
                                input logic [31:0] pc, input logic rdy, input logic fl);
      @(posedge clk);
      #2;
      reset = rst; in_valid = v; in_word = w; in_pc = pc; out_ready = rdy; flush = fl;
      @(negedge clk);
   endtask

   initial begin
      reset = 1; in_valid = 0; in_word = 0; in_pc = 0; out_ready = 0; flush = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_stall", {31'd0, fetch_stall}, 32'd0);
      checkOutput("reset_inst", {16'd0, out_inst}, 32'd0);
      checkOutput("reset_pc", out_pc, 32'd0);

      // Three single-word instructions back to back
      applyStimulus(0, 1, 16'h1000, 32'h20, 1, 0);
      applyStimulus(0, 1, 16'h1002, 32'h21, 1, 0);
      checkOutput("seq_pc0", out_pc, 32'h20);
      applyStimulus(0, 1, 16'h1004, 32'h22, 1, 0);
      checkOutput("seq_pc1", out_pc, 32'h21);
      applyStimulus(0, 0, 16'h0, 32'h0, 1, 0);
      checkOutput("seq_pc2", out_pc, 32'h22);
      checkOutput("seq_valid2", {31'd0, out_valid}, 32'd1);
      applyStimulus(0, 0, 16'h0, 32'h0, 1, 0);
      checkOutput("seq_drained", {31'd0, out_valid}, 32'd0);

      // Two-word instruction, then held under back-pressure
      applyStimulus(0, 1, 16'h3001, 32'h40, 1, 0);
      applyStimulus(0, 1, 16'hBEEF, 32'h99, 0, 0);
      checkOutput("imm_gap_valid", {31'd0, out_valid}, 32'd0);
      applyStimulus(0, 0, 16'h0, 32'h0, 0, 0);
      checkOutput("imm_inst", {16'd0, out_inst}, 32'h3001);
      checkOutput("imm_imm", {16'd0, out_imm}, 32'hBEEF);
      checkOutput("imm_has", {31'd0, out_has_imm}, 32'd1);
      checkOutput("imm_pc", out_pc, 32'h40);
      checkOutput("hold_stall", {31'd0, fetch_stall}, 32'd1);
      applyStimulus(0, 0, 16'h0, 32'h0, 0, 0);
      applyStimulus(0, 0, 16'h0, 32'h0, 0, 0);
      checkOutput("hold_inst", {16'd0, out_inst}, 32'h3001);
      checkOutput("hold_stall3", {31'd0, fetch_stall}, 32'd1);
      applyStimulus(0, 1, 16'h2000, 32'h50, 1, 0);
      checkOutput("drain_stall", {31'd0, fetch_stall}, 32'd0);
      applyStimulus(0, 0, 16'h0, 32'h0, 1, 0);
      checkOutput("accept_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("accept_inst", {16'd0, out_inst}, 32'h2000);
      checkOutput("accept_imm", {16'd0, out_imm}, 32'h0);
      applyStimulus(0, 0, 16'h0, 32'h0, 1, 0);

      // Flush discards a partial opcode and the word in the flush cycle
      applyStimulus(0, 1, 16'h5001, 32'h60, 1, 0);
      applyStimulus(0, 1, 16'h1234, 32'h61, 1, 1);
      applyStimulus(0, 1, 16'h0A00, 32'h0, 1, 0);
      checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("flush_has", {31'd0, out_has_imm}, 32'd0);
      checkOutput("flush_imm", {16'd0, out_imm}, 32'd0);
      checkOutput("flush_stale_inst", {16'd0, out_inst}, 32'h5001);
      checkOutput("flush_stale_pc", out_pc, 32'h60);
      applyStimulus(0, 0, 16'h0, 32'h0, 1, 0);
      checkOutput("post_flush_inst", {16'd0, out_inst}, 32'h0A00);
      checkOutput("post_flush_valid", {31'd0, out_valid}, 32'd1);

      // Second two-word instruction
      applyStimulus(0, 1, 16'h7001, 32'h70, 1, 0);
      applyStimulus(0, 1, 16'h1111, 32'h71, 1, 0);
      applyStimulus(0, 0, 16'h0, 32'h0, 1, 0);
      checkOutput("imm2_imm", {16'd0, out_imm}, 32'h1111);
      applyStimulus(0, 0, 16'h0, 32'h0, 1, 0);

      checkOutput("model_delivered", m_delivered, 32'd7);
      checkOutput("model_delivered_imm", m_delivered_imm, 32'd2);
      checkOutput("model_flushed", m_flushed, 32'd1);
`ifdef INST_WORD_ASSEMBLER_STATS_EN
      checkOutput("stat_insts", stat_insts, 32'd7);
      checkOutput("stat_imm_insts", stat_imm_insts, 32'd2);
      checkOutput("stat_flushed", {16'd0, stat_flushed}, 32'd1);
`endif

      // Reset while a bundle is held
      applyStimulus(0, 1, 16'h0100, 32'h80, 0, 0);
      applyStimulus(0, 0, 16'h0, 32'h0, 0, 0);
      checkOutput("full_before_reset", {31'd0, out_valid}, 32'd1);
      applyStimulus(1, 0, 16'h0, 32'h0, 0, 0);
      applyStimulus(0, 0, 16'h0, 32'h0, 0, 0);
      checkOutput("rst2_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst2_stall", {31'd0, fetch_stall}, 32'd0);
      checkOutput("rst2_inst", {16'd0, out_inst}, 32'd0);
      checkOutput("rst2_imm", {16'd0, out_imm}, 32'd0);
      checkOutput("rst2_has", {31'd0, out_has_imm}, 32'd0);
      checkOutput("rst2_pc", out_pc, 32'd0);
`ifdef INST_WORD_ASSEMBLER_STATS_EN
      checkOutput("rst2_stat_insts", stat_insts, 32'd0);
`endif

      applyStimulus(0, 0, 16'h0, 32'h0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
